grid_node_sequencer: RTL and testbench
======================================

// Module: grid_node_sequencer
// PURPOSE
//  Generates the (x,y) lattice-node address stream that drives per-node LBM stages (wall classification,
//  collision, streaming). On Start, walks every node of an X_DIM x Y_DIM grid exactly once.
//  y is the fast (inner) index and x the slow (outer) index. Each node is presented over a valid/ready
//  handshake. Optionally attaches the boundary class of each node. Sits between the LBM controller and
//  the per-node datapath.
// PARAMETERS
//  X_DIM    16                       rows (x range 0..X_DIM-1); min 2
//  Y_DIM    16                       cols (y range 0..Y_DIM-1); min 3
//  X_WIDTH  $clog2(X_DIM)            x address width
//  Y_WIDTH  $clog2(Y_DIM)            y address width
// PORTS
//  Clk          in   1        clock; all state updates on posedge
//  Reset        in   1        synchronous, active-high reset
//  Start        in   1        begin a sweep; honoured only in IDLE
//  Abort        in   1        terminate sweep; highest priority after Reset
//  Ready        in   1        consumer accepts current node
//  Valid        out  1        x/y/flags hold a node
//  x            out  X_WIDTH  node row
//  y            out  Y_WIDTH  node col
//  Last         out  1        current node is (X_DIM-1, Y_DIM-1)
//  Busy         out  1        state != IDLE
//  Done         out  1        1-cycle pulse after last node accepted
//  LID          out  1        boundary class (WALL_FLAGS_EN)
//  BOTTOM_WALL  out  1        boundary class (WALL_FLAGS_EN)
//  LEFT_WALL    out  1        boundary class (WALL_FLAGS_EN)
//  RIGHT_WALL   out  1        boundary class (WALL_FLAGS_EN)
// BEHAVIOUR
//  - Reset (sync, active-high) → IDLE. All outputs 0: Valid, x, y, Last, Busy, Done and the four flags.
//  - FSM states IDLE, SCAN, DONE.
//  - IDLE:
//    - Start=1 → SCAN next cycle with x=0, y=0, Valid=1.
//    - Start is ignored in SCAN and DONE.
//  - SCAN:
//    - Valid=1 throughout.
//    - Outputs are held stable while Ready=0.
//    - Handshake = Valid&Ready; the address advances on the handshake edge only.
//    - Advance rule: y+1. If y==Y_DIM-1 then y=0 and x+1.
//    - Handshake with Last=1 → DONE; Valid=0 next cycle.
//    - Sustains 1 node/cycle with Ready held high: full sweep = X_DIM*Y_DIM cycles,
//      Start to Done = X_DIM*Y_DIM+1 cycles.
//  - DONE: Done=1 for exactly one cycle, then → IDLE. x/y return to 0.
//  - Last is combinational from the registered x/y; =1 only at (X_DIM-1, Y_DIM-1) while Valid=1.
//  - Abort=1 in any state → IDLE next cycle.
//    - Valid=0, x=y=0.
//    - Done is NOT pulsed.
//    - Abort overrides a simultaneous handshake and a simultaneous Start.
//  - Reset mid-sweep behaves as Abort and also clears flags.
//  - Counters never wrap past the grid. No address outside the grid is ever presented with Valid=1.
// CONFIGURATION
//  - Macro WALL_FLAGS_EN.
//  - Defined: the flags are registered and aligned with x/y (same cycle, same stall hold).
//    - Flags are mutually exclusive, in priority order:
//      LID: x==X_DIM-1 && 1<=y<=Y_DIM-2
//      > BOTTOM_WALL: x==0
//      > LEFT_WALL: y==0
//      > RIGHT_WALL: y==Y_DIM-1
//    - Corners resolve by that priority: (0,0)→BOTTOM, (X_DIM-1,0)→LEFT, (X_DIM-1,Y_DIM-1)→RIGHT.
//    - Interior nodes → all 0.
//    - All flags are 0 whenever Valid=0.
//  - Undefined: the four flag ports remain present, tied to 0. No flag logic is synthesised.
//    Consumer must classify externally.
// TESTING (16x16 default; run with and without WALL_FLAGS_EN)
//  - Reset=1 for 2 cycles mid-sweep → all outputs 0, state IDLE. Start 1 cycle later restarts at (0,0).
//  - Start, Ready held 1 → 256 handshakes in order (0,0),(0,1)..(0,15),(1,0)..(15,15).
//    Last only on (15,15). Done pulses on cycle 257 after Start. Busy=0 on the cycle after Done.
//  - Random Ready stalls (~50%) → identical 256-node order. x/y/flags stable across every Ready=0 cycle.
//    No duplicated or skipped node.
//  - Abort asserted during the handshake of node (7,3) → next cycle Valid=0, x=y=0, Busy=0, no Done pulse.
//    Start is ignored while Abort=1.
//  - WALL_FLAGS_EN defined → (0,0)=BOTTOM, (15,0)=LEFT, (15,15)=RIGHT, (15,7)=LID, (8,15)=RIGHT,
//    (8,0)=LEFT, (8,8)=none. Exactly one flag on 60 nodes, zero on 196 nodes.
//  - WALL_FLAGS_EN undefined → all four flags 0 for the entire sweep.
//  - Start re-asserted during SCAN and during DONE → ignored. The sweep sequence and Done timing are unchanged.

Source files
------------

// File: rtl/grid_node_sequencer_if.sv
// -----------------------------------------------------------------------------
// grid_node_sequencer_if
//   Handshake and node-address bundle between the LBM controller/consumer and
//   grid_node_sequencer.
//   master modport : the sequencer side (drives the node stream).
//   slave modport  : the controller/consumer side.
//   Signals:
//     start, abort  controller commands
//     ready         consumer accepts the current node
//     valid         x/y/flags hold a node
//     x, y          node row / node column
//     last          current node is the final grid node
//     busy          sequencer is not idle
//     done          one-cycle pulse after the last node is accepted
//     lid, bottom_wall, left_wall, right_wall
//                   boundary class of the current node (zero when the
//                   WALL_FLAGS_EN feature is not built)
// -----------------------------------------------------------------------------
interface grid_node_sequencer_if #(
    parameter int X_WIDTH = 4,
    parameter int Y_WIDTH = 4
);
    logic               start;
    logic               abort;
    logic               ready;
    logic               valid;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               last;
    logic               busy;
    logic               done;
    logic               lid;
    logic               bottom_wall;
    logic               left_wall;
    logic               right_wall;

    modport master (
        input  start, abort, ready,
        output valid, x, y, last, busy, done,
        output lid, bottom_wall, left_wall, right_wall
    );

    modport slave (
        output start, abort, ready,
        input  valid, x, y, last, busy, done,
        input  lid, bottom_wall, left_wall, right_wall
    );
endinterface

// File: rtl/grid_node_sequencer.sv
// -----------------------------------------------------------------------------
// grid_node_sequencer
//   Walks every node of an X_DIM x Y_DIM lattice exactly once per start,
//   y fast (inner), x slow (outer), presenting each node over valid/ready.
//   The address advances only on a valid&ready handshake, so a stalled
//   consumer sees x/y/flags held stable.
//
//   Ports:
//     clk    clock, all state updates on the rising edge
//     Reset  synchronous, active-high reset (returns to idle, clears outputs)
//     bus    grid_node_sequencer_if.master (start/abort/ready in,
//            valid/x/y/last/busy/done/boundary flags out)
//
//   Optional feature, macro WALL_FLAGS_EN:
//     defined   -> registered, mutually exclusive boundary flags aligned with
//                  x/y (priority lid > bottom_wall > left_wall > right_wall)
//     undefined -> the four flag outputs are tied to 0
// -----------------------------------------------------------------------------
module grid_node_sequencer #(
    parameter int X_DIM   = 16,
    parameter int Y_DIM   = 16,
    parameter int X_WIDTH = $clog2(X_DIM),
    parameter int Y_WIDTH = $clog2(Y_DIM)
) (
    input  logic                   clk,
    input  logic                   Reset,
    grid_node_sequencer_if.master  bus
);

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_DIM - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_DIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [X_WIDTH-1:0] x_reg, x_next;
    logic [Y_WIDTH-1:0] y_reg, y_next;
    logic [3:0]         flags;      // {lid, bottom_wall, left_wall, right_wall}
    logic               at_last;

    assign at_last = (x_reg == X_LAST) && (y_reg == Y_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    // ----------------------------------------------------------- next state
    // The address is parked at (0,0) whenever the sequencer is not scanning,
    // so a new sweep can begin without a separate clear step.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        if (bus.abort) begin
            state_next = ST_IDLE;
            x_next     = '0;
            y_next     = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_next = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (bus.ready) begin
                        if (at_last) begin
                            state_next = ST_DONE;
                            x_next     = '0;
                            y_next     = '0;
                        end else if (y_reg == Y_LAST) begin
                            y_next = '0;
                            x_next = x_reg + X_WIDTH'(1);
                        end else begin
                            y_next = y_reg + Y_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                    x_next     = '0;
                    y_next     = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------- boundary flags
`ifdef WALL_FLAGS_EN
    logic [3:0] flags_reg, flags_next;

    // Classified from the next address so the registered flags line up with
    // the registered x/y and hold with them during stalls. Cleared whenever
    // the next cycle will not present a valid node.
    always_comb begin
        flags_next = 4'b0000;
        if (state_next == ST_SCAN) begin
            if ((x_next == X_LAST) && (y_next != '0) && (y_next != Y_LAST)) begin
                flags_next = 4'b1000;
            end else if (x_next == '0) begin
                flags_next = 4'b0100;
            end else if (y_next == '0) begin
                flags_next = 4'b0010;
            end else if (y_next == Y_LAST) begin
                flags_next = 4'b0001;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            flags_reg <= 4'b0000;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign flags = flags_reg;
`else
    assign flags = 4'b0000;
`endif

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.valid       = (state_reg == ST_SCAN);
        bus.x           = x_reg;
        bus.y           = y_reg;
        bus.last        = (state_reg == ST_SCAN) && at_last;
        bus.busy        = (state_reg != ST_IDLE);
        bus.done        = (state_reg == ST_DONE);
        bus.lid         = flags[3];
        bus.bottom_wall = flags[2];
        bus.left_wall   = flags[1];
        bus.right_wall  = flags[0];
    end

endmodule

// File: tb/tb_grid_node_sequencer.sv
// -----------------------------------------------------------------------------
// tb_grid_node_sequencer
//   Randomized-stall bench for grid_node_sequencer (16x16). The expected node
//   order, boundary class and timing come from plain row/column arithmetic.
//   Build with and without +define+WALL_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_grid_node_sequencer;

    localparam int XD = 16;
    localparam int YD = 16;
    localparam int N  = XD * YD;

`ifdef WALL_FLAGS_EN
    localparam int EXP_FLAGGED = 2 * XD + 2 * (YD - 2);
`else
    localparam int EXP_FLAGGED = 0;
`endif

    logic clk;
    logic Reset;

    grid_node_sequencer_if #(.X_WIDTH(4), .Y_WIDTH(4)) bus ();

    grid_node_sequencer #(.X_DIM(XD), .Y_DIM(YD)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Boundary class of a grid node from its coordinates.
    function automatic logic [3:0] exp_flags(input int xi, input int yi);
        logic [3:0] f;
        f = 4'b0000;
`ifdef WALL_FLAGS_EN
        if (xi == XD - 1 && yi >= 1 && yi <= YD - 2) f = 4'b1000;
        else if (xi == 0)                            f = 4'b0100;
        else if (yi == 0)                            f = 4'b0010;
        else if (yi == YD - 1)                       f = 4'b0001;
`endif
        return f;
    endfunction

    function automatic logic [3:0] obs_flags();
        return {bus.lid, bus.bottom_wall, bus.left_wall, bus.right_wall};
    endfunction

    function automatic logic [31:0] all_outputs();
        return {16'd0, bus.valid, bus.x, bus.y, bus.last, bus.busy, bus.done, obs_flags()};
    endfunction

    task automatic check_idle(input string tag);
        check_eq(tag, all_outputs(), 32'd0);
    endtask

    // One sweep. stall_pct: chance (%) of ready=0 per cycle. abort_idx: node
    // index at whose handshake abort is raised (-1 = none). poke: drive random
    // start during the sweep and start during the done cycle.
    task automatic sweep(input int stall_pct, input int abort_idx, input bit poke);
        int         idx;
        int         cyc;
        int         flagged;
        int         hs_ready;
        bit         held;
        logic [7:0] prev_xy;
        logic [3:0] prev_f;
        int         ex, ey;

        idx = 0; cyc = 0; flagged = 0; held = 1'b0;
        prev_xy = '0; prev_f = '0;
        bus.start = 1'b1;
        bus.ready = 1'b0;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (idx < N) begin
            if (cyc > N * 20) begin
                check_eq("sweep_timeout", idx, N);
                return;
            end
            ex = idx / YD;
            ey = idx % YD;
            check_eq("valid", bus.valid, 1);
            check_eq("xy", {bus.x, bus.y}, {ex[3:0], ey[3:0]});
            check_eq("last", bus.last, (idx == N - 1) ? 1 : 0);
            check_eq("flags", obs_flags(), exp_flags(ex, ey));
            check_eq("busy_done", {bus.busy, bus.done}, 2'b10);
            if (held) begin
                check_eq("hold_xy", {bus.x, bus.y}, prev_xy);
                check_eq("hold_flags", obs_flags(), prev_f);
            end
            prev_xy = {bus.x, bus.y};
            prev_f  = obs_flags();

            hs_ready  = ($urandom_range(99) >= stall_pct) ? 1 : 0;
            bus.ready = hs_ready[0];
            bus.start = poke ? 1'($urandom_range(1)) : 1'b0;
            bus.abort = (idx == abort_idx) && (hs_ready != 0);
            if (bus.abort) bus.start = 1'b1;
            step();
            cyc++;

            if (bus.abort) begin
                check_idle("abort_next");
                // Start while abort stays high must be ignored.
                bus.ready = 1'b0;
                step();
                check_idle("abort_start_held");
                bus.abort = 1'b0;
                bus.start = 1'b0;
                step();
                check_idle("abort_no_done");
                $display("sweep abort at node (%0d,%0d) stall=%0d%%", ex, ey, stall_pct);
                return;
            end
            if (hs_ready != 0) begin
                if ($countones(prev_f) == 1) flagged++;
                check_eq("flags_onehot", ($countones(prev_f) <= 1) ? 1 : 0, 1);
                idx++;
                held = 1'b0;
            end else begin
                held = 1'b1;
            end
        end
        bus.ready = 1'b0;
        bus.start = poke;
        check_eq("done_state", all_outputs(), {16'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 4'd0});
        if (stall_pct == 0) check_eq("done_cycle", cyc, N + 1);
        check_eq("flagged_nodes", flagged, EXP_FLAGGED);
        check_eq("plain_nodes", N - flagged, N - EXP_FLAGGED);
        step();
        bus.start = 1'b0;
        check_idle("after_done");
        step();
        check_idle("idle_settled");
        $display("sweep complete: %0d nodes in %0d cycles stall=%0d%% poke=%0d flagged=%0d",
                 idx, cyc, stall_pct, poke, flagged);
    endtask

    initial begin
        Reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ready = 1'b0;
        step();
        step();
        check_idle("reset");
        Reset = 1'b0;
        step();
        check_idle("idle");

        sweep(0, -1, 1'b0);
        sweep(50, -1, 1'b0);
        sweep(35, -1, 1'b1);
        sweep(40, 7 * YD + 3, 1'b0);

        // Reset in the middle of a sweep, then restart one cycle later.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.ready = 1'b1;
        repeat (20) step();
        check_eq("midsweep_busy", bus.busy, 1);
        Reset = 1'b1;
        step();
        step();
        Reset     = 1'b0;
        bus.ready = 1'b0;
        check_idle("mid_reset");
        $display("mid-sweep reset applied");
        step();
        check_idle("mid_reset_idle");
        sweep(0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
